mpu_matrix_loader: RTL
======================

MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to begin loading a new matrix.
REQ-004 SHALL have port cfg_size, input, 8 signed, matrix order sampled on an accepted start; legal range 1..5.
REQ-005 SHALL have port elem_in, input, 8 signed, matrix element data.
REQ-006 SHALL have port elem_valid, input, 1, elem_in holds a valid element.
REQ-007 SHALL have port elem_ready, output, 1, loader accepts an element this cycle.
REQ-008 SHALL have port matrix, output, 200 [199:0], packed 5x5 signed 8-bit matrix, element (r,c) at bits [r*40 + c*8 +: 8].
REQ-009 SHALL have port size, output, 8 signed, latched order of the matrix on the matrix port.
REQ-010 SHALL have port matrix_valid, output, 1, matrix and size complete and stable.
REQ-011 SHALL have port matrix_ack, input, 1, consumer has taken the matrix.
REQ-012 SHALL have port busy, output, 1, high in LOAD or HOLD.
REQ-013 SHALL have port error, output, 1, one-cycle pulse on a rejected start or an aborted load.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, HOLD, all registered.
REQ-015 In IDLE, start=1 with cfg_size in 1..5 SHALL latch size, zero all 200 matrix bits, clear row/col counters, and enter LOAD next cycle.
REQ-016 In IDLE, start=1 with cfg_size outside 1..5 SHALL pulse error for one cycle, stay in IDLE, and leave matrix and size unchanged.
REQ-017 elem_ready SHALL equal 1 exactly in LOAD; an element is accepted on a cycle where elem_valid and elem_ready are both 1.
REQ-018 Accepted elements SHALL be written row-major into positions (row,col), row,col in 0..size-1; col wraps to 0 and row increments after col = size-1.
REQ-019 Positions with row >= size or col >= size SHALL remain zero.
REQ-020 Acceptance of element size*size-1 SHALL move the FSM to HOLD; matrix_valid SHALL rise the following cycle, one cycle after the final accept.
REQ-021 In HOLD, matrix, size and matrix_valid SHALL stay constant until matrix_ack=1, which returns the FSM to IDLE and drops matrix_valid the next cycle.
REQ-022 matrix and size SHALL hold their last values in IDLE until the next accepted start.
REQ-023 start SHALL be ignored in LOAD and HOLD; matrix_ack SHALL be ignored outside HOLD.
REQ-024 elem_valid SHALL be ignored outside LOAD; the element count SHALL never exceed size*size.
REQ-025 A size-1 load SHALL complete after exactly one accepted element.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, matrix=0, size=0, matrix_valid=0, elem_ready=0, busy=0, error=0, counters=0, including mid-LOAD or mid-HOLD.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With macro MPU_LOADER_TIMEOUT_EN defined, an 8-bit idle counter SHALL run in LOAD, clear on every accepted element, and on reaching 255 abort to IDLE with a one-cycle error pulse; matrix contents are then undefined-but-stable and matrix_valid stays 0.
REQ-029 Without MPU_LOADER_TIMEOUT_EN, LOAD SHALL wait indefinitely and no timeout logic SHALL be present.

Verification
REQ-030 start with cfg_size=2, elements 1,2,3,4 each valid for one cycle -> matrix[7:0]=1, [15:8]=2, [47:40]=3, [55:48]=4, all other bits 0, size=2, matrix_valid high one cycle after the 4th accept.
REQ-031 start with cfg_size=0, then 6 -> error pulses one cycle each, busy stays 0, matrix unchanged.
REQ-032 cfg_size=3, elements -1..-9 with elem_valid toggling every other cycle, matrix_ack delayed 10 cycles -> exactly 9 accepts, matrix_valid held 10 cycles with matrix stable, then IDLE.
REQ-033 start pulse during LOAD with cfg_size=1 -> ignored; load continues with original size.
REQ-034 rst_n low after 5 of 16 elements of a size-4 load -> all outputs reset immediately; a new size-1 load of 8'sd7 then gives matrix[7:0]=7.
REQ-035 With MPU_LOADER_TIMEOUT_EN, start size 2, one element, then 255 idle cycles -> error pulse, FSM IDLE, matrix_valid never asserted.

Source files
------------

// File: rtl/mpu_matrix_loader.sv
// ---------------------------------------------------------------------------
// mpu_matrix_loader
//
// Collects a square signed 8-bit matrix of order 1..5 from an element stream
// and presents it, zero-padded to 5x5, until the consumer acknowledges it.
//
// Ports
//   clk          : sole clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : request to begin loading a new matrix (honoured in IDLE)
//   cfg_size     : signed matrix order, sampled on an accepted start (1..5)
//   elem_in      : signed element data
//   elem_valid   : elem_in holds a valid element
//   elem_ready   : loader accepts an element this cycle (high only in LOAD)
//   matrix       : packed 5x5 matrix, element (r,c) at [r*40 + c*8 +: 8]
//   size         : latched order of the matrix on the matrix port
//   matrix_valid : matrix and size complete and stable
//   matrix_ack   : consumer has taken the matrix (honoured in HOLD)
//   busy         : high in LOAD or HOLD
//   error        : one-cycle pulse on a rejected start or an aborted load
//
// Optional feature
//   MPU_LOADER_TIMEOUT_EN : when defined, a load that sees no accepted element
//   for 255 cycles is abandoned with an error pulse. When undefined, LOAD
//   waits indefinitely.
// ---------------------------------------------------------------------------
module mpu_matrix_loader (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [7:0]  cfg_size,
    input  logic signed [7:0]  elem_in,
    input  logic               elem_valid,
    output logic               elem_ready,
    output logic [199:0]       matrix,
    output logic signed [7:0]  size,
    output logic               matrix_valid,
    input  logic               matrix_ack,
    output logic               busy,
    output logic               error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] row_q, col_q;
    logic [2:0] last_idx;
    logic [7:0] wr_base;
    logic       cfg_ok;
    logic       accept;
    logic       last_elem;
    logic       abort;

    // Signed compare: a negative cfg_size must be rejected, not read as a
    // large unsigned value.
    assign cfg_ok    = (cfg_size >= 8'sd1) && (cfg_size <= 8'sd5);
    assign accept    = elem_valid && elem_ready;
    // Only the low three bits of a legal size are meaningful (1..5).
    assign last_idx  = size[2:0] - 3'd1;
    assign last_elem = (row_q == last_idx) && (col_q == last_idx);
    assign wr_base   = ({5'd0, row_q} * 8'd40) + ({5'd0, col_q} * 8'd8);

`ifdef MPU_LOADER_TIMEOUT_EN
    logic [7:0] idle_cnt_q;

    // Counts LOAD cycles without an accepted element; restarts on every
    // accept and is held at zero outside LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= 8'd0;
        end else if ((state_q != LOAD) || accept) begin
            idle_cnt_q <= 8'd0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
        end
    end

    // Fires on the edge where the count would reach 255.
    assign abort = (state_q == LOAD) && !accept && (idle_cnt_q == 8'd254);
`else
    assign abort = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        elem_ready = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                elem_ready = 1'b1;
                busy       = 1'b1;
                if (elem_valid && last_elem) begin
                    state_d = HOLD;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (matrix_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: matrix storage, counters, status flags
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the matrix storage is 200 plain flops, not a RAM, so it
            // can and must be cleared by the asynchronous reset.
            matrix       <= '0;
            size         <= 8'sd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            matrix_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            size   <= cfg_size;
                            matrix <= '0;
                            row_q  <= 3'd0;
                            col_q  <= 3'd0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        matrix[wr_base +: 8] <= elem_in;
                        if (col_q == last_idx) begin
                            col_q <= 3'd0;
                            row_q <= row_q + 3'd1;
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                        if (last_elem) begin
                            matrix_valid <= 1'b1;
                        end
                    end else if (abort) begin
                        error <= 1'b1;
                    end
                end
                HOLD: begin
                    if (matrix_ack) begin
                        matrix_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
